// File: rtl/fft16_out_serializer_pkg.sv
// Shared constants, types and helpers for the FFT output serializer.
// Lane vectors pack lane k at bits [k*DW +: DW].
package fft16_out_serializer_pkg;

  localparam int DW  = 17;
  localparam int N   = 16;
  localparam int LGN = $clog2(N);

  typedef logic [LGN-1:0] idx_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  function automatic idx_t bitrev(input idx_t x);
    idx_t r;
    r = '0;
    for (int b = 0; b < LGN; b++) begin
      r[b] = x[LGN-1-b];
    end
    return r;
  endfunction

  function automatic logic signed [DW-1:0] lane_slice(input logic [N*DW-1:0] vec,
                                                      input idx_t k);
    return vec[k*DW +: DW];
  endfunction

endpackage

// File: rtl/fft16_pingpong_bank.sv
// One frame of complex storage: whole-frame write in a single cycle,
// combinational single-lane read. Contents are intentionally not reset.
module fft16_pingpong_bank
  import fft16_out_serializer_pkg::*;
(
  input  logic            clk,
  input  logic            wr_en_i,
  input  logic [N*DW-1:0] wr_re_i,
  input  logic [N*DW-1:0] wr_im_i,
  input  idx_t            rd_lane_i,
  output cplx_t           rd_data_o
);

  logic [N*DW-1:0] re_q;
  logic [N*DW-1:0] im_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      re_q <= wr_re_i;
      im_q <= wr_im_i;
    end
  end

  assign rd_data_o.re = lane_slice(re_q, rd_lane_i);
  assign rd_data_o.im = lane_slice(im_q, rd_lane_i);

endmodule

// File: rtl/fft16_out_serializer.sv
// Captures a 16-lane FFT frame into a ping-pong buffer and streams it out one
// complex sample per cycle, optionally undoing the bit-reversed lane order.
module fft16_out_serializer
  import fft16_out_serializer_pkg::*;
#(
  parameter bit BITREV = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      data_i_R,
  input  logic [N*DW-1:0]      data_i_I,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [LGN-1:0]       out_idx,
  output logic                 out_last,
  output logic                 busy
);

  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  idx_t       cnt_q, cnt_d;

  logic       accept;
  logic       fire;
  idx_t       rd_lane;
  logic       bank_we [2];
  cplx_t      bank_rd [2];
  cplx_t      sample;

  assign accept  = in_valid & in_ready;
  assign fire    = out_valid & out_ready;
  assign rd_lane = BITREV ? bitrev(cnt_q) : cnt_q;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign bank_we[g] = accept & (wr_sel_q == 1'(g));

    fft16_pingpong_bank u_bank (
      .clk       (clk),
      .wr_en_i   (bank_we[g]),
      .wr_re_i   (data_i_R),
      .wr_im_i   (data_i_I),
      .rd_lane_i (rd_lane),
      .rd_data_o (bank_rd[g])
    );
  end

  // Ready depends only on state (and reset), never on out_ready.
  always_comb begin
    in_ready  = rst_n & ~full_q[wr_sel_q];
    out_valid = full_q[rd_sel_q];
    out_idx   = cnt_q;
    out_last  = out_valid & (cnt_q == idx_t'(N-1));
    busy      = |full_q;
    sample    = bank_rd[rd_sel_q];
    out_re    = out_valid ? sample.re : '0;
    out_im    = out_valid ? sample.im : '0;
  end

  // Capture and release always target different banks, so both may fire at once.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    cnt_d    = cnt_q;
    if (accept) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (fire) begin
      cnt_d = cnt_q + idx_t'(1);
      if (cnt_q == idx_t'(N-1)) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fft16_out_serializer.sv
// Scoreboard bench: runs a BITREV=1 and a BITREV=0 instance side by side on
// identical stimulus and checks every output cycle against a queue model.
module tb_fft16_out_serializer;

  localparam int DW  = 17;
  localparam int N   = 16;
  localparam int LGN = 4;

  typedef struct {
    int idx;
    int re1;
    int im1;
    int re0;
    int im0;
  } expSample_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic out_ready;
  logic [N*DW-1:0] dataR;
  logic [N*DW-1:0] dataI;

  logic                 inReadyA, outValidA, outLastA, busyA;
  logic signed [DW-1:0] outReA, outImA;
  logic [LGN-1:0]       outIdxA;
  logic                 inReadyB, outValidB, outLastB, busyB;
  logic signed [DW-1:0] outReB, outImB;
  logic [LGN-1:0]       outIdxB;

  expSample_t sbQ[$];
  int curFrame;
  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  fft16_out_serializer #(.BITREV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyA),
    .data_i_R(dataR), .data_i_I(dataI), .out_valid(outValidA), .out_ready(out_ready),
    .out_re(outReA), .out_im(outImA), .out_idx(outIdxA), .out_last(outLastA), .busy(busyA)
  );

  fft16_out_serializer #(.BITREV(1'b0)) dutNat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyB),
    .data_i_R(dataR), .data_i_I(dataI), .out_valid(outValidB), .out_ready(out_ready),
    .out_re(outReB), .out_im(outImB), .out_idx(outIdxB), .out_last(outLastB), .busy(busyB)
  );

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
  endtask

  function automatic int tbRev(input int x);
    int r = 0;
    for (int b = 0; b < LGN; b++) if (((x >> b) & 1) != 0) r |= 1 << (LGN-1-b);
    return r;
  endfunction

  // Monitor: compare state and the front sample first, then pop/push for this edge.
  always @(negedge clk) begin
    int frames;
    expSample_t e;
    if (rst_n) begin
      frames = (sbQ.size() + N - 1) / N;
      checkOutput("outValid", outValidA, sbQ.size() != 0);
      checkOutput("outValidNat", outValidB, sbQ.size() != 0);
      checkOutput("busy", busyA, frames != 0);
      checkOutput("busyNat", busyB, frames != 0);
      checkOutput("inReady", inReadyA, frames < 2);
      checkOutput("inReadyNat", inReadyB, frames < 2);
      if (outValidA && sbQ.size() != 0) begin
        e = sbQ[0];
        checkOutput("idx", outIdxA, e.idx);
        checkOutput("idxNat", outIdxB, e.idx);
        checkOutput("last", outLastA, e.idx == N-1);
        checkOutput("lastNat", outLastB, e.idx == N-1);
        checkOutput("reRev", outReA, e.re1);
        checkOutput("imRev", outImA, e.im1);
        checkOutput("reNat", outReB, e.re0);
        checkOutput("imNat", outImB, e.im0);
        if (out_ready) void'(sbQ.pop_front());
      end else if (!outValidA) begin
        checkOutput("idleRe", outReA, 0);
        checkOutput("idleLast", outLastA, 0);
      end
      if (in_valid && inReadyA) begin
        for (int i = 0; i < N; i++) begin
          e.idx = i;
          e.re1 = 100*tbRev(i) + 1000*curFrame;
          e.im1 = -tbRev(i) - 16*curFrame;
          e.re0 = 100*i + 1000*curFrame;
          e.im0 = -i - 16*curFrame;
          sbQ.push_back(e);
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int f);
    curFrame = f;
    for (int k = 0; k < N; k++) begin
      dataR[k*DW +: DW] = DW'(100*k + 1000*f);
      dataI[k*DW +: DW] = DW'(-k - 16*f);
    end
    in_valid = 1'b1;
    stepCycle();
    in_valid = 1'b0;
  endtask

  task automatic waitIdx(input int idx);
    bit found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (outValidA && int'(outIdxA) == idx) begin
        found = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput("reachIdx", found, 1);
  endtask

  task automatic drain(input int limit);
    for (int c = 0; c < limit; c++) begin
      if (sbQ.size() == 0) break;
      stepCycle();
    end
    checkOutput("drained", sbQ.size(), 0);
    stepCycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dataR     = '0;
    dataI     = '0;
    curFrame  = 0;
    repeat (2) stepCycle();
    checkOutput("rstInReady", inReadyA, 0);
    checkOutput("rstOutValid", outValidA, 0);
    checkOutput("rstOutRe", outReA, 0);
    checkOutput("rstBusy", busyA, 0);
    checkOutput("rstIdx", outIdxA, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("relInReady", inReadyA, 1);
    checkOutput("relBusy", busyA, 0);
    stepCycle();

    // Single frame, both lane orders.
    applyStimulus(0);
    checkOutput("firstValid", outValidA, 1);
    checkOutput("firstIdx", outIdxA, 0);
    drain(60);

    // Back-pressure at bin 5.
    applyStimulus(1);
    waitIdx(5);
    out_ready = 1'b0;
    repeat (3) stepCycle();
    checkOutput("bpIdxHeld", outIdxA, 5);
    checkOutput("bpReHeld", outReA, 100*tbRev(5) + 1000);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("bpResume", outIdxA, 6);
    drain(60);

    // Ping-pong: A, gap, B, then C offered while both banks are full.
    applyStimulus(2);
    stepCycle();
    applyStimulus(3);
    curFrame = 4;
    in_valid = 1'b1;
    checkOutput("cBlocked", inReadyA, 0);
    stepCycle();
    in_valid = 1'b0;
    drain(80);

    // Reset mid-frame with a second frame buffered.
    applyStimulus(5);
    stepCycle();
    applyStimulus(6);
    waitIdx(7);
    #2;
    rst_n = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("midRstValid", outValidA, 0);
    checkOutput("midRstBusy", busyA, 0);
    checkOutput("midRstInReady", inReadyA, 0);
    checkOutput("midRstIdx", outIdxA, 0);
    repeat (2) stepCycle();
    rst_n = 1'b1;
    stepCycle();
    applyStimulus(7);
    checkOutput("dFirstIdx", outIdxA, 0);
    checkOutput("dFirstRe", outReA, 7000);
    drain(60);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fft16_out_serializer.md
Name: fft16_out_serializer

Overview:
Reader for the parallel 16-lane complex vectors produced by the final FFT butterfly stage. It captures a whole frame in one cycle into a ping-pong buffer and streams it out one complex sample per cycle over a valid/ready interface. With BITREV=1 it restores natural bin order from the bit-reversed lane order. Sits between the last butterfly stage and the downstream consumer (IFFT path, magnitude, or host interface).

Parameters:
DW, 17, signed width of each real/imag sample (matches butterfly data width)
N, 16, points per frame; power of two; index width LGN = log2(N) = 4
BITREV, 1, 1: emitted bin k is read from lane bitrev(k); 0: read from lane k

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  frame strobe; all lanes valid this cycle
in_ready  out  1  a free bank is available; frame accepted when in_valid & in_ready
data_i_R  in  N*DW  packed real lanes; lane k = [k*DW +: DW], signed
data_i_I  in  N*DW  packed imag lanes, same packing
out_valid  out  1  out_re/out_im/out_idx/out_last valid
out_ready  in  1  consumer accepts the sample
out_re  out  DW  signed real sample
out_im  out  DW  signed imag sample
out_idx  out  LGN  bin number of the current sample (0..N-1)
out_last  out  1  high with bin N-1
busy  out  1  either bank full

Behaviour:
- State: two banks of N complex words (bank0, bank1); full[1:0]; wr_sel; rd_sel; cnt[LGN-1:0]. All registered.
- Reset (async, rst_n low): full=0, wr_sel=0, rd_sel=0, cnt=0. in_ready forced 0 while rst_n low and 1 after release. Bank contents are don't-care and need not be reset. out_valid, out_last, busy are 0. out_re, out_im, out_idx are 0.
- Capture: in_ready = !full[wr_sel], computed from registers only (no combinational path from out_ready).
  - On in_valid & in_ready: bank[wr_sel] <= data, full[wr_sel] <= 1, wr_sel toggles.
  - in_valid while in_ready=0 is ignored. The data is not held and no error is flagged. The upstream must hold or retry.
- Emit: out_valid = full[rd_sel]; out_idx = cnt; out_last = out_valid & (cnt == N-1).
  - Lane read = BITREV ? bitrev(cnt) : cnt.
  - out_re/out_im = that lane of bank[rd_sel] when out_valid, else 0.
- Handshake: on out_valid & out_ready, cnt increments.
  - If cnt == N-1: cnt wraps to 0, full[rd_sel] <= 0, rd_sel toggles.
  - Outputs hold stable while out_valid & !out_ready.
- Latency: frame accepted at edge t gives out_valid=1 with bin 0 after edge t. Throughput is 1 sample/cycle. Back-to-back frames stream with no bubble if the next frame was captured before the last sample of the current one.
- Simultaneous last-read and capture: capture can only target a bank with full=0, so the two never collide. A bank freed at edge t is writable from cycle t+1 (in_ready rises one cycle later).
- Both banks full: in_ready=0 until the current frame's last handshake.
- No arithmetic; samples pass bit-exact, no rescaling.
- Reset mid-frame: both frames are discarded and streaming restarts from bin 0 of the next captured frame.
- busy = full[0] | full[1].

Decomposition:
- Shared package: DW, N, LGN constants; a bitrev function over LGN bits; the lane slice helper.
- One sub-module: fft16_pingpong_bank, holding the N x 2*DW storage with a one-cycle full-vector write port and a combinational lane-select read port (instanced twice, or one with a bank select).
- FSM/counter logic stays in the top.

Test Plan:
- Reset then idle: rst_n low -> in_ready=0, out_valid=0, out_re=0. Release -> in_ready=1, busy=0.
- Single frame, BITREV=1, lane k = (re=100k, im=-k), out_ready=1 -> out_valid next cycle.
  - Expected sequence (idx,re,im): (0,0,0), (1,800,-8), (2,400,-4), (3,1200,-12) ... (15,1500,-15).
  - out_last only at idx 15; then out_valid=0.
- BITREV=0, same frame -> out_re = 100*idx, out_im = -idx for idx 0..15.
- Back-pressure: out_ready low for 3 cycles at idx 5 -> idx 5 values held, cnt frozen. Resumes at idx 6 when out_ready rises.
- Ping-pong: frame A, then frame B two cycles later, out_ready=1 -> 32 consecutive valid samples with no gap.
  - Frame C offered while both banks full -> in_ready=0, not captured.
  - in_ready returns to 1 the cycle after A's idx 15 handshake.
- Reset at idx 7 of frame A with frame B buffered -> out_valid=0 immediately, busy=0. A new frame D then streams from idx 0.
